// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter: shares one i2c_master between NREQ requesters.
// The arbiter picks one requester round-robin and latches its rw/addr/data.
// It then drives m_start for XFER_CYCLES cycles and m_stop for STOP_CYCLES cycles.
// Finally it pulses req_done for the owner on the first IDLE cycle.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no transaction; round-robin scan offers req_ready to one valid
// ST_START | m_start held high while the transfer timer counts down
// ST_STOP  | m_stop held high while the stop timer counts down
module i2c_txn_arbiter #(
    parameter int NREQ        = 4,
    parameter int XFER_CYCLES = 20,
    parameter int STOP_CYCLES = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ-1:0]         req_rw,
    input  logic [7*NREQ-1:0]       req_addr,
    input  logic [8*NREQ-1:0]       req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic [NREQ-1:0]         req_done,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    m_start,
    output logic                    m_stop,
    output logic                    m_rw,
    output logic [6:0]              m_addr,
    output logic [7:0]              m_data
);

    localparam int IW   = $clog2(NREQ);
    localparam int CMAX = (XFER_CYCLES > STOP_CYCLES) ? XFER_CYCLES : STOP_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    // Timer is loaded with N-1 so that the phase lasts N cycles, ending at zero.
    localparam logic [CW-1:0] XFER_LOAD = CW'(XFER_CYCLES - 1);
    localparam logic [CW-1:0] STOP_LOAD = CW'(STOP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_STOP  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            start_q, start_d;
    logic            stop_q, stop_d;
    logic            rw_q, rw_d;
    logic [6:0]      addr_q, addr_d;
    logic [7:0]      data_q, data_d;

    logic            found;
    logic [IW-1:0]   sel;

    // Round-robin scan: first valid requester at or after the pointer, with wrap.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_valid[IW'((int'(rr_q) + k) % NREQ)]) begin
                found = 1'b1;
                sel   = IW'((int'(rr_q) + k) % NREQ);
            end
        end
    end

    // Accept strobe is offered only in IDLE and never while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (state_q == ST_IDLE && !reset && found) begin
            req_ready[sel] = 1'b1;
        end
    end

    // Next-state, timer, payload latch and completion pulse.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        done_d  = '0;
        start_d = start_q;
        stop_d  = stop_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                start_d = 1'b0;
                stop_d  = 1'b0;
                if (found) begin
                    state_d = ST_START;
                    start_d = 1'b1;
                    cnt_d   = XFER_LOAD;
                    rw_d    = req_rw[sel];
                    addr_d  = req_addr[7*sel +: 7];
                    data_d  = req_data[8*sel +: 8];
                    grant_d = sel;
                    rr_d    = IW'((int'(sel) + 1) % NREQ);
                end
            end
            ST_START: begin
                if (cnt_q == '0) begin
                    state_d = ST_STOP;
                    start_d = 1'b0;
                    stop_d  = 1'b1;
                    cnt_d   = STOP_LOAD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == '0) begin
                    state_d         = ST_IDLE;
                    stop_d          = 1'b0;
                    done_d[grant_q] = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                start_d = 1'b0;
                stop_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any transaction and clears the payload.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rr_q    <= '0;
            grant_q <= '0;
            done_q  <= '0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign req_done = done_q;
    assign busy     = (state_q != ST_IDLE);
    assign grant_id = grant_q;
    assign m_start  = start_q;
    assign m_stop   = stop_q;
    assign m_rw     = rw_q;
    assign m_addr   = addr_q;
    assign m_data   = data_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Self-checking bench for i2c_txn_arbiter.
// Main instance: 4 requesters, 20/5 timing. Second instance: 2 requesters, 1/1 timing.
module tb_i2c_txn_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid, req_rw, req_ready, req_done;
    logic [27:0] req_addr;
    logic [31:0] req_data;
    logic        busy, m_start, m_stop, m_rw;
    logic [1:0]  grant_id;
    logic [6:0]  m_addr;
    logic [7:0]  m_data;

    logic [1:0]  b_valid, b_rw, b_ready, b_done;
    logic [13:0] b_addr;
    logic [15:0] b_data;
    logic        b_busy, b_start, b_stop, b_mrw;
    logic [0:0]  b_grant;
    logic [6:0]  b_maddr;
    logic [7:0]  b_mdata;

    i2c_txn_arbiter #(.NREQ(4), .XFER_CYCLES(20), .STOP_CYCLES(5)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_rw(req_rw),
        .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
        .req_done(req_done), .busy(busy), .grant_id(grant_id), .m_start(m_start),
        .m_stop(m_stop), .m_rw(m_rw), .m_addr(m_addr), .m_data(m_data)
    );

    i2c_txn_arbiter #(.NREQ(2), .XFER_CYCLES(1), .STOP_CYCLES(1)) dut_b (
        .clk(clk), .reset(reset), .req_valid(b_valid), .req_rw(b_rw),
        .req_addr(b_addr), .req_data(b_data), .req_ready(b_ready),
        .req_done(b_done), .busy(b_busy), .grant_id(b_grant), .m_start(b_start),
        .m_stop(b_stop), .m_rw(b_mrw), .m_addr(b_maddr), .m_data(b_mdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] vec;
        int         id;
        logic       rw;
        logic [6:0] addr;
        logic [7:0] data;
    } ev_t;

    ev_t exp_q[$];
    ev_t acc_log[$];
    ev_t start_log[$];
    ev_t done_log[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int overlap_cnt = 0;
    int rdy_busy_cnt = 0;
    int rw_low_cnt = 0;
    logic prev_start = 1'b0;

    logic [3:0] s_ready, s_done;
    logic       s_start, s_stop, s_busy, s_rw;
    logic [6:0] s_addr;
    logic [7:0] s_data;
    logic [1:0] s_grant;

    function automatic ev_t mk(int id, logic rw, logic [6:0] a, logic [7:0] d);
        ev_t e;
        e.cyc  = 0;
        e.vec  = 4'b0001 << id;
        e.id   = id;
        e.rw   = rw;
        e.addr = a;
        e.data = d;
        return e;
    endfunction

    task automatic set_req(int i, logic rw, logic [6:0] a, logic [7:0] d);
        req_rw[i]         = rw;
        req_addr[7*i +: 7] = a;
        req_data[8*i +: 8] = d;
    endtask

    // Called at a negedge: samples the current cycle, logs events, advances one cycle.
    task automatic step();
        ev_t e;
        #1;
        s_ready = req_ready; s_done = req_done; s_start = m_start; s_stop = m_stop;
        s_busy = busy; s_rw = m_rw; s_addr = m_addr; s_data = m_data; s_grant = grant_id;
        e = mk(0, m_rw, m_addr, m_data);
        e.cyc = cyc;
        if ((req_ready & req_valid) != 4'b0) begin
            e.vec = req_ready & req_valid;
            for (int i = 0; i < 4; i++) if (e.vec[i]) e.id = i;
            acc_log.push_back(e);
        end
        if (m_start && !prev_start) begin
            e.id  = int'(grant_id);
            e.vec = 4'b0;
            start_log.push_back(e);
        end
        if (req_done != 4'b0) begin
            e.vec = req_done;
            done_log.push_back(e);
        end
        if (m_start && m_stop) overlap_cnt++;
        if (busy && req_ready != 4'b0) rdy_busy_cnt++;
        if (busy && !m_rw) rw_low_cnt++;
        prev_start = m_start;
        cyc++;
        @(negedge clk);
    endtask

    task automatic clear_logs();
        exp_q.delete(); acc_log.delete(); start_log.delete(); done_log.delete();
        overlap_cnt = 0; rdy_busy_cnt = 0; rw_low_cnt = 0;
    endtask

    task automatic apply_reset();
        reset = 1'b1; req_valid = '0; b_valid = '0;
        step(); step();
        reset = 1'b0;
        clear_logs();
    endtask

    // Bounded run: stops once n_done completions were seen or max_cyc elapsed.
    task automatic run(int max_cyc, int n_done, bit drop);
        for (int i = 0; i < max_cyc; i++) begin
            step();
            if (drop) req_valid = req_valid & ~s_ready;
            if (done_log.size() >= n_done) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (s_ready !== 4'b0) begin
                failures++;
                $display("FAIL reset_ready cyc%0d got=%b want=0000", i, s_ready);
            end
        end
        reset = 1'b0;
        req_valid = '0;
        step();
        checks++;
        if ({s_start, s_stop, s_busy, s_rw, s_addr, s_data, s_grant, s_done} !== 25'b0) begin
            failures++;
            $display("FAIL reset_outputs got st=%b sp=%b bz=%b rw=%b a=%h d=%h g=%0d dn=%b want all zero",
                     s_start, s_stop, s_busy, s_rw, s_addr, s_data, s_grant, s_done);
        end
        clear_logs();
    endtask

    task automatic test_single();
        logic [6:0] obs, expv;
        ev_t x;
        apply_reset();
        set_req(0, 1'b0, 7'h55, 8'hAA);
        req_valid = 4'b0001;
        exp_q.push_back(mk(0, 1'b0, 7'h55, 8'hAA));
        step();
        checks++;
        if (s_ready !== 4'b0001) begin
            failures++;
            $display("FAIL single_ready got=%b want=0001", s_ready);
        end
        req_valid = '0;
        for (int k = 1; k <= 26; k++) begin
            step();
            expv = {(k <= 20), (k >= 21 && k <= 25), (k <= 25), ((k == 26) ? 4'b0001 : 4'b0000)};
            obs  = {s_start, s_stop, s_busy, s_done};
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL single_timing k=%0d got{start,stop,busy,done}=%b want=%b", k, obs, expv);
            end
        end
        checks++;
        if (start_log.size() != 1 || done_log.size() != 1 || acc_log.size() != 1) begin
            failures++;
            $display("FAIL single_events got acc=%0d start=%0d done=%0d want 1 each",
                     acc_log.size(), start_log.size(), done_log.size());
        end else begin
            x = exp_q.pop_front();
            checks++;
            if ({start_log[0].rw, start_log[0].addr, start_log[0].data} !== {x.rw, x.addr, x.data}) begin
                failures++;
                $display("FAIL single_payload got rw=%b a=%h d=%h want rw=%b a=%h d=%h",
                         start_log[0].rw, start_log[0].addr, start_log[0].data, x.rw, x.addr, x.data);
            end
            checks++;
            if (done_log[0].cyc - acc_log[0].cyc != 26 || done_log[0].vec !== x.vec) begin
                failures++;
                $display("FAIL single_done got delay=%0d vec=%b want delay=26 vec=%b",
                         done_log[0].cyc - acc_log[0].cyc, done_log[0].vec, x.vec);
            end
        end
        checks++;
        if ({s_addr, s_data} !== {7'h55, 8'hAA}) begin
            failures++;
            $display("FAIL single_hold got a=%h d=%h want a=55 d=aa", s_addr, s_data);
        end
    endtask

    task automatic test_simultaneous();
        ev_t x;
        apply_reset();
        set_req(1, 1'b0, 7'h11, 8'h22);
        set_req(3, 1'b1, 7'h33, 8'h44);
        exp_q.push_back(mk(1, 1'b0, 7'h11, 8'h22));
        exp_q.push_back(mk(3, 1'b1, 7'h33, 8'h44));
        req_valid = 4'b1010;
        run(150, 2, 1'b1);
        checks++;
        if (acc_log.size() != 2 || done_log.size() != 2 || start_log.size() != 2) begin
            failures++;
            $display("FAIL simul_events got acc=%0d start=%0d done=%0d want 2 each",
                     acc_log.size(), start_log.size(), done_log.size());
        end else begin
            checks++;
            if (acc_log[1].cyc - acc_log[0].cyc != 26) begin
                failures++;
                $display("FAIL simul_spacing got=%0d want=26", acc_log[1].cyc - acc_log[0].cyc);
            end
            for (int i = 0; i < 2; i++) begin
                x = exp_q.pop_front();
                checks++;
                if (acc_log[i].id != x.id || done_log[i].vec !== x.vec ||
                    {start_log[i].rw, start_log[i].addr, start_log[i].data} !== {x.rw, x.addr, x.data}) begin
                    failures++;
                    $display("FAIL simul_txn%0d got id=%0d done=%b rw=%b a=%h d=%h want id=%0d done=%b rw=%b a=%h d=%h",
                             i, acc_log[i].id, done_log[i].vec, start_log[i].rw, start_log[i].addr,
                             start_log[i].data, x.id, x.vec, x.rw, x.addr, x.data);
                end
            end
        end
    endtask

    task automatic test_fairness();
        ev_t x;
        apply_reset();
        for (int i = 0; i < 4; i++) set_req(i, i[0], 7'(8'h40 + i), 8'(8'hC0 + i));
        for (int n = 0; n < 8; n++) exp_q.push_back(mk(n % 4, n[0], 7'(8'h40 + (n % 4)), 8'(8'hC0 + (n % 4))));
        req_valid = 4'b1111;
        run(400, 8, 1'b0);
        req_valid = '0;
        checks++;
        if (done_log.size() < 8 || start_log.size() < 8) begin
            failures++;
            $display("FAIL fair_events got start=%0d done=%0d want 8", start_log.size(), done_log.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                x = exp_q.pop_front();
                checks++;
                if (start_log[i].id != x.id || done_log[i].vec !== x.vec ||
                    {start_log[i].addr, start_log[i].data} !== {x.addr, x.data}) begin
                    failures++;
                    $display("FAIL fair_txn%0d got grant=%0d done=%b a=%h d=%h want grant=%0d done=%b a=%h d=%h",
                             i, start_log[i].id, done_log[i].vec, start_log[i].addr, start_log[i].data,
                             x.id, x.vec, x.addr, x.data);
                end
            end
        end
        checks++;
        if (rdy_busy_cnt != 0 || overlap_cnt != 0) begin
            failures++;
            $display("FAIL fair_invariants got ready_while_busy=%0d start_stop_overlap=%0d want 0,0",
                     rdy_busy_cnt, overlap_cnt);
        end
    endtask

    task automatic test_back_to_back();
        ev_t x;
        apply_reset();
        set_req(2, 1'b1, 7'h55, 8'h01);
        exp_q.push_back(mk(2, 1'b1, 7'h55, 8'h01));
        exp_q.push_back(mk(2, 1'b1, 7'h55, 8'h01));
        req_valid = 4'b0100;
        run(200, 2, 1'b0);
        req_valid = '0;
        checks++;
        if (acc_log.size() < 2 || done_log.size() < 2 || start_log.size() < 2) begin
            failures++;
            $display("FAIL b2b_events got acc=%0d start=%0d done=%0d want 2",
                     acc_log.size(), start_log.size(), done_log.size());
        end else begin
            checks++;
            if (done_log[0].cyc != acc_log[1].cyc || acc_log[1].vec !== 4'b0100) begin
                failures++;
                $display("FAIL b2b_same_cycle got done_cyc=%0d reaccept_cyc=%0d vec=%b want equal cycles vec=0100",
                         done_log[0].cyc, acc_log[1].cyc, acc_log[1].vec);
            end
            for (int i = 0; i < 2; i++) begin
                x = exp_q.pop_front();
                checks++;
                if (done_log[i].vec !== x.vec ||
                    {start_log[i].rw, start_log[i].addr, start_log[i].data} !== {x.rw, x.addr, x.data}) begin
                    failures++;
                    $display("FAIL b2b_txn%0d got done=%b rw=%b a=%h d=%h want done=%b rw=%b a=%h d=%h",
                             i, done_log[i].vec, start_log[i].rw, start_log[i].addr, start_log[i].data,
                             x.vec, x.rw, x.addr, x.data);
                end
            end
        end
        checks++;
        if (rw_low_cnt != 0) begin
            failures++;
            $display("FAIL b2b_rw got busy_cycles_with_rw0=%0d want 0", rw_low_cnt);
        end
    endtask

    task automatic test_reset_mid();
        ev_t x;
        apply_reset();
        set_req(0, 1'b1, 7'h12, 8'h34);
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        repeat (9) step();
        reset = 1'b1;
        step();
        checks++;
        if (s_start !== 1'b1 || s_ready !== 4'b0) begin
            failures++;
            $display("FAIL rstmid_pre got start=%b ready=%b want start=1 ready=0000", s_start, s_ready);
        end
        reset = 1'b0;
        clear_logs();
        step();
        checks++;
        if ({s_start, s_stop, s_busy, s_rw, s_addr, s_data, s_grant, s_done} !== 25'b0) begin
            failures++;
            $display("FAIL rstmid_outputs got st=%b sp=%b bz=%b rw=%b a=%h d=%h g=%0d dn=%b want all zero",
                     s_start, s_stop, s_busy, s_rw, s_addr, s_data, s_grant, s_done);
        end
        repeat (30) step();
        checks++;
        if (done_log.size() != 0) begin
            failures++;
            $display("FAIL rstmid_no_done got done_pulses=%0d want 0", done_log.size());
        end
        set_req(0, 1'b0, 7'h55, 8'hAA);
        set_req(3, 1'b0, 7'h0F, 8'hF0);
        exp_q.push_back(mk(0, 1'b0, 7'h55, 8'hAA));
        exp_q.push_back(mk(3, 1'b0, 7'h0F, 8'hF0));
        req_valid = 4'b1001;
        run(150, 2, 1'b1);
        checks++;
        if (acc_log.size() != 2 || done_log.size() != 2 || start_log.size() != 2) begin
            failures++;
            $display("FAIL rstmid_fresh_events got acc=%0d start=%0d done=%0d want 2",
                     acc_log.size(), start_log.size(), done_log.size());
        end else begin
            checks++;
            if (done_log[0].cyc - acc_log[0].cyc != 26) begin
                failures++;
                $display("FAIL rstmid_fresh_delay got=%0d want=26", done_log[0].cyc - acc_log[0].cyc);
            end
            for (int i = 0; i < 2; i++) begin
                x = exp_q.pop_front();
                checks++;
                if (acc_log[i].id != x.id || done_log[i].vec !== x.vec ||
                    {start_log[i].addr, start_log[i].data} !== {x.addr, x.data}) begin
                    failures++;
                    $display("FAIL rstmid_fresh%0d got id=%0d done=%b a=%h d=%h want id=%0d done=%b a=%h d=%h",
                             i, acc_log[i].id, done_log[i].vec, start_log[i].addr, start_log[i].data,
                             x.id, x.vec, x.addr, x.data);
                end
            end
        end
    endtask

    task automatic test_boundary();
        logic [4:0] obs, expv;
        apply_reset();
        b_rw = 2'b01;
        b_addr = {7'h00, 7'h2A};
        b_data = {8'h00, 8'h5C};
        b_valid = 2'b01;
        #1;
        checks++;
        if (b_ready !== 2'b01) begin
            failures++;
            $display("FAIL bnd_ready got=%b want=01", b_ready);
        end
        step();
        b_valid = '0;
        for (int k = 1; k <= 4; k++) begin
            obs  = {b_start, b_stop, b_busy, b_done};
            expv = {(k == 1), (k == 2), (k <= 2), ((k == 3) ? 2'b01 : 2'b00)};
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL bnd_timing k=%0d got{start,stop,busy,done}=%b want=%b", k, obs, expv);
            end
            if (k == 1) begin
                checks++;
                if ({b_mrw, b_maddr, b_mdata} !== {1'b1, 7'h2A, 8'h5C}) begin
                    failures++;
                    $display("FAIL bnd_payload got rw=%b a=%h d=%h want rw=1 a=2a d=5c",
                             b_mrw, b_maddr, b_mdata);
                end
            end
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        req_valid = '0; req_rw = '0; req_addr = '0; req_data = '0;
        b_valid = '0; b_rw = '0; b_addr = '0; b_data = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_back_to_back();
        test_reset_mid();
        test_boundary();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_txn_arbiter.md
Name: i2c_txn_arbiter

Overview:
- Shares one i2c_master between NREQ independent requesters. Each requester presents one I2C transaction: rw, 7-bit address and 8-bit data.
- The arbiter picks a requester round-robin and latches its payload. It then sequences the master's start/stop controls with fixed, parameterised timing.
- It returns a one-cycle done pulse to the owning requester. It sits directly in front of i2c_master and drives its start, stop, rw, addr and data inputs.

Parameters:
NREQ, 4, number of requesters (2..8).
XFER_CYCLES, 20, cycles m_start is held high per transaction (>=1).
STOP_CYCLES, 5, cycles m_stop is held high after m_start drops (>=1).

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
req_valid  in  NREQ  bit i: requester i has a pending transaction.
req_rw  in  NREQ  bit i: requester i direction (1 = read).
req_addr  in  7*NREQ  slice [7i+6:7i]: requester i target address.
req_data  in  8*NREQ  slice [8i+7:8i]: requester i write data.
req_ready  out  NREQ  one-hot combinational accept; transaction i is taken at the edge where valid&ready.
req_done  out  NREQ  one-hot registered one-cycle completion pulse.
busy  out  1  high whenever state != IDLE.
grant_id  out  clog2(NREQ)  index of the current/last owner.
m_start  out  1  to i2c_master start.
m_stop  out  1  to i2c_master stop.
m_rw  out  1  to i2c_master rw.
m_addr  out  7  to i2c_master addr.
m_data  out  8  to i2c_master data.

Behaviour:
- Reset values (synchronous, any state): state=IDLE; rr pointer=0; m_start=0; m_stop=0; m_rw=0; m_addr=0; m_data=0; req_done=0; grant_id=0; busy=0.
- Reset mid-transaction aborts immediately. No req_done is generated and the payload is cleared.
- Arbitration: in IDLE, scan req_valid starting at pointer p, ascending with wrap. The first set bit i gets req_ready[i]=1. All other req_ready bits are 0.
- req_ready is 0 in every non-IDLE state and while reset is high.
- Acceptance edge (IDLE with any valid):
  - latch req_rw[i], addr slice and data slice into m_rw, m_addr and m_data;
  - set grant_id=i;
  - set p=(i+1) mod NREQ;
  - go to START.
- Requesters hold valid and payload stable until accepted. Dropping valid before acceptance is legal, and that requester is simply not chosen. Payload changes after acceptance have no effect.
- START state:
  - m_start=1 and m_stop=0;
  - m_start rises the cycle after acceptance and stays high exactly XFER_CYCLES cycles, counted by a down-counter loaded at acceptance;
  - then go to STOP.
- STOP state: m_start=0 and m_stop=1 for exactly STOP_CYCLES cycles, then go to IDLE.
- req_done: on the STOP->IDLE edge, req_done[grant_id] is registered high for exactly one cycle, the first IDLE cycle.
  - A new acceptance may occur in that same cycle. A requester may re-request and be granted there if it is the first valid at p.
- IDLE outputs: m_start=0 and m_stop=0. m_rw, m_addr and m_data hold their last latched values.
- busy=1 in START and STOP.
- Minimum transaction period: 1 + XFER_CYCLES + STOP_CYCLES cycles from one acceptance to the next.
- Only the owner's req_done bit ever pulses. m_start and m_stop are never high in the same cycle.

Test Plan:
- Single request: req_valid=0001, rw=0, addr=0x55, data=0xAA; XFER=20, STOP=5.
  -> req_ready[0] for 1 cycle.
  -> m_start high cycles 1..20 with m_addr=0x55, m_data=0xAA, m_rw=0.
  -> m_stop high cycles 21..25.
  -> req_done[0] at cycle 26.
  -> busy high cycles 1..25.
- Simultaneous requests: req_valid=1010 after reset (p=0).
  -> grant 1 first, then grant 3.
  -> second acceptance exactly 26 cycles after the first.
  -> req_done order 0010, then 1000.
- Fairness: all four requesters valid continuously for 8 transactions.
  -> grant_id sequence 0,1,2,3,0,1,2,3.
  -> no req_ready while busy.
- Back-to-back same requester: req_valid=0100 held with rw=1, addr=0x55, data=0x01.
  -> req_done[2] and the next req_ready[2] occur in the same cycle.
  -> m_rw=1 throughout.
- Reset during START: assert reset at cycle 10 of START.
  -> the next cycle has m_start=0, busy=0, all outputs zero, p=0.
  -> no req_done pulse.
  -> a fresh request afterwards behaves as in the single-request case.
- Boundary timing with XFER_CYCLES=1, STOP_CYCLES=1:
  -> m_start is a 1-cycle pulse, followed by a 1-cycle m_stop pulse.
  -> req_done 3 cycles after acceptance.
